serial_parity_receiver: RTL
===========================

Name: serial_parity_receiver

Overview:
- Frame receiver for a serial bit stream carrying a DATA_W-bit word followed by one parity bit.
- It deserialises the word LSB-first and accumulates XOR parity across data and parity bits.
- One cycle after the parity bit it presents the word with a pass/fail flag.
- Sits directly downstream of the XOR/XNOR gate library; its parity accumulator is the sequential consumer of that XOR function.

Parameters:
- DATA_W, 8, number of data bits per frame (2..32).
- ODD, 0, parity sense: 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  frame-start strobe; one cycle wide.
- in_valid  input  1  in_bit is sampled on this cycle when high.
- in_bit  input  1  serial data/parity bit.
- data_out  output  DATA_W  last completed word; holds until the next frame completes.
- out_valid  output  1  one-cycle pulse marking data_out/parity_err updated.
- parity_err  output  1  parity result of last completed frame; 1 = mismatch.
- busy  output  1  high while in DATA or PARITY state.

Behaviour:
- Reset (asynchronous on rst_n low):
  - state=IDLE; data_out=0, out_valid=0, parity_err=0, busy=0.
  - Bit counter, shift register and parity accumulator all cleared.
  - A reset mid-frame discards the frame and produces no out_valid.
- States: IDLE, DATA, PARITY. All outputs are registered.
- IDLE:
  - start=1 -> DATA; counter=0, accumulator=0, shift register=0.
  - in_valid/in_bit on the start cycle are ignored.
- DATA:
  - Each cycle with in_valid=1: shift in_bit in LSB-first (bit k of the word = k-th accepted bit), accumulator ^= in_bit, counter++.
  - When the DATA_W-th bit is accepted -> PARITY.
  - in_valid=0 cycles are gaps: no state change. Gaps of any length are legal.
- PARITY:
  - First cycle with in_valid=1: total = accumulator ^ in_bit.
  - parity_err <= (total != ODD); data_out <= shift register; out_valid <= 1 on the next edge; state -> IDLE.
- Latency: out_valid is high exactly one clock after the edge that samples the parity bit. It is never high two consecutive cycles.
- start while busy (DATA or PARITY):
  - The current frame is aborted with no out_valid, and data_out/parity_err are unchanged.
  - The block restarts in DATA with counter/accumulator/shift register cleared.
  - start takes priority over in_valid in that cycle; that cycle's in_bit is dropped.
- Back-to-back frames: start may be asserted in the cycle out_valid is high, because the state is already IDLE. No dead cycle is required.
- busy=1 from the edge after start through the edge that samples the parity bit.
- Counter width is clog2(DATA_W+1). The counter never wraps within a frame.

Decomposition:
- Shared package:
  - State encoding constants IDLE=2'd0, DATA=2'd1, PARITY=2'd2.
  - Parity sense constants PAR_EVEN=0, PAR_ODD=1.
- One sub-module, parity_accumulator:
  - A single flop with synchronous clear and enabled XOR-toggle (acc <= clr ? 0 : en ? acc^d : acc).
  - Async active-low reset on clk/rst_n.
  - Built on the team's XOR gate cell.

Test Plan:
- Reset: hold rst_n=0 with start and in_valid toggling -> data_out=0, out_valid=0, parity_err=0, busy=0 throughout.
- Even parity, good frame: start, then bits of 0xA5 LSB-first, then parity bit 0, no gaps -> out_valid one cycle after parity, data_out=8'hA5, parity_err=0, busy low afterwards.
- Even parity, bad frame: same as above with parity bit 1 -> data_out=8'hA5, parity_err=1. Then a back-to-back start in the out_valid cycle, frame 0x00 with parity 0 -> data_out=8'h00, parity_err=0.
- Gaps plus ODD=1: frame 0x01 with parity bit 0, random in_valid=0 gaps of 1-5 cycles between bits -> data_out=8'h01, parity_err=0. Same frame with parity 1 -> parity_err=1.
- Abort: start, 4 bits, start again, then full frame 0x3C with parity 0 -> exactly one out_valid, data_out=8'h3C, parity_err=0. Previous outputs unchanged until then.
- Async reset mid-frame: pull rst_n low between clock edges after 5 data bits -> outputs clear immediately, no out_valid. After release, a full 0xFF/parity 0 frame -> data_out=8'hFF, parity_err=0.

Source files
------------

// File: rtl/serial_parity_receiver_pkg.sv
// Shared types and constants for the serial parity frame receiver.
package serial_parity_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // A frame is bad when the XOR of all its bits disagrees with the parity sense.
  function automatic logic parity_mismatch(input logic total, input logic sense);
    return total ^ sense;
  endfunction

endpackage

// File: rtl/serial_parity_receiver_parity_accumulator.sv
// Single-flop running XOR with synchronous clear and enable.
module parity_accumulator (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic d_i,
  output logic acc_o
);

  logic acc_q;
  logic acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = 1'b0;
    end else if (en_i) begin
      acc_d = acc_q ^ d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/serial_parity_receiver.sv
// LSB-first serial word receiver with trailing parity bit and pass/fail flag.
module serial_parity_receiver
  import serial_parity_receiver_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = PAR_EVEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic                busy_q, busy_d;
  logic                acc_clr;
  logic                acc_en;
  logic                acc;

  parity_accumulator u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .d_i   (in_bit),
    .acc_o (acc)
  );

  // Next-state and output logic; start always wins over in_valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;

    if (start) begin
      state_d = DATA;
      cnt_d   = '0;
      shift_d = '0;
      acc_clr = 1'b1;
    end else begin
      case (state_q)
        DATA: begin
          if (in_valid) begin
            shift_d = {in_bit, shift_q[DATA_W-1:1]};
            acc_en  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (in_valid) begin
            perr_d  = parity_mismatch(acc ^ in_bit, ODD);
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign out_valid  = valid_q;
  assign parity_err = perr_q;
  assign busy       = busy_q;

endmodule
